multicycle_ctrl_fsm: RTL
========================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multicycle MIPS control unit; the producer side of the ALU interface. It decodes
//  opcode/funct, sequences FETCH->DECODE->EXEC->MEM->WB and drives AluControl plus all
//  datapath enables and selects. It sits between the instruction register and the
//  datapath (PC, memory, register file, ALU) and consumes the ALU zero flag for beq.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles a memory state waits for memReady before memFault (1..255)
// PORTS
//  clk           in   1  system clock, rising edge
//  resetN        in   1  asynchronous, active-low reset
//  opcode        in   6  instr[31:26] from instruction register
//  funct         in   6  instr[5:0] from instruction register
//  zero          in   1  ALU zero flag (1 = result==0)
//  memReady      in   1  memory handshake: access completes in the cycle it is 1
//  AluControl    out  4  0000 add,0001 sub,0010 not,0011 lsl,0100 lsr,0101 and,0110 or,0111 slt
//  aluSrcA       out  1  0=PC, 1=regA
//  aluSrcB       out  2  00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2
//  pcWrite       out  1  unconditional PC load
//  pcWriteCond   out  1  PC load qualified by zero (beq)
//  pcSource      out  2  00=ALU result, 01=ALUOut reg, 10=jump target
//  iorD          out  1  memory address: 0=PC, 1=ALUOut
//  memRead       out  1  memory read strobe
//  memWrite      out  1  memory write strobe
//  irWrite       out  1  instruction register load
//  regDst        out  1  0=rt, 1=rd
//  memToReg      out  1  0=ALUOut, 1=MDR
//  regWrite      out  1  register file write
//  illegalInstr  out  1  sticky illegal-opcode flag (see CONFIGURATION)
//  memFault      out  1  one-cycle pulse on memory timeout
//  state         out  4  current state encoding, debug only
// BEHAVIOUR
//  - Reset: state=IDLE; every output 0, except state=0000. IDLE->FETCH next clock.
//  - Outputs decode from the state register. irWrite/pcWrite in FETCH are gated by memReady.
//  - FETCH: memRead=1, iorD=0, srcA=0, srcB=01, add; on memReady: irWrite=1, pcWrite=1,
//    pcSource=00, ->DECODE. Otherwise hold.
//  - DECODE: srcA=0, srcB=11, add (branch target into ALUOut). Next state by opcode:
//    0x00 R->REXEC; 0x23 lw, 0x2B sw->MEMADDR; 0x04 beq->BRANCH; 0x02 j->JUMP;
//    0x08 addi->IEXEC; other->ILLEGAL.
//  - REXEC: srcA=1, srcB=00, AluControl by funct: 20 add, 22 sub, 24 and, 25 or, 2A slt,
//    00 lsl, 02 lsr, 27 not. Unlisted funct->ILLEGAL. ->RWB: regDst=1, memToReg=0, regWrite=1.
//  - MEMADDR: srcA=1, srcB=10, add. lw->MEMREAD (memRead=1, iorD=1; wait memReady)->MEMWB
//    (regDst=0, memToReg=1, regWrite=1). sw->MEMWRITE (memWrite=1, iorD=1; wait memReady).
//  - IEXEC: srcA=1, srcB=10, add. ->IWB: regDst=0, memToReg=0, regWrite=1.
//  - BRANCH: srcA=1, srcB=00, sub, pcWriteCond=1, pcSource=01. Taken iff zero=1.
//  - JUMP: pcWrite=1, pcSource=10.
//  - Every terminal state (RWB, MEMWB, MEMWRITE done, IWB, BRANCH, JUMP) ->FETCH.
//  - Latency at memReady=1: beq/j 3, R/addi/sw 4, lw 5 cycles.
//  - Wait counter: 8 bits, cleared on entry to FETCH/MEMREAD/MEMWRITE and incremented per
//    waiting cycle. When count==MEM_TIMEOUT-1 with memReady=0: memFault=1 for one cycle,
//    ->IDLE. No PC, IR or register write happens, so the same PC is refetched.
//  - If memReady and timeout fall in the same cycle, memReady wins: normal completion.
//  - Non-memory states ignore memReady.
//  - In states where AluControl is not listed, it is 0000 and all strobes are 0.
//  - resetN low at any time: IDLE immediately, with no clock edge needed. An interrupted
//    write is dropped, and illegalInstr clears.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: ILLEGAL sets illegalInstr=1 (sticky until reset) and holds
//    ILLEGAL with all strobes 0; only reset exits.
//  ILLEGAL_TRAP_EN undefined: ILLEGAL goes to FETCH next cycle as a NOP, with no writes;
//    illegalInstr is tied 0.
// TESTING
//  1 reset, then opcode=00 funct=22, memReady=1 -> IDLE,FETCH,DECODE,REXEC(AluControl=0001),
//    RWB(regWrite=1, regDst=1), FETCH on cycle 6.
//  2 lw (0x23), memReady low 3 cycles in MEMREAD -> memRead,iorD held 4 cycles, then MEMWB
//    with memToReg=1, regWrite=1, exactly once.
//  3 beq (0x04) with zero=1 and then zero=0 -> BRANCH: AluControl=0001, pcWriteCond=1,
//    pcSource=01 in both cases; pcWrite=0.
//  4 FETCH with memReady=0 for 16 cycles (MEM_TIMEOUT=16) -> memFault pulse on cycle 16, IDLE,
//    no irWrite; memReady on cycle 16 instead -> normal DECODE, no fault.
//  5 opcode=0x3F: TRAP_EN -> illegalInstr=1, stuck until resetN=0; no TRAP_EN -> FETCH, no writes.
//  6 resetN asserted mid-MEMWRITE -> memWrite drops without a clock edge; all outputs 0.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS control FSM: decodes opcode/funct and drives datapath strobes and ALU control.
// Optional macro ILLEGAL_TRAP_EN: illegal instructions trap (sticky illegalInstr) instead of NOP.
module multicycle_ctrl_fsm #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       memReady,
   output logic [3:0] AluControl,
   output logic       aluSrcA,
   output logic [1:0] aluSrcB,
   output logic       pcWrite,
   output logic       pcWriteCond,
   output logic [1:0] pcSource,
   output logic       iorD,
   output logic       memRead,
   output logic       memWrite,
   output logic       irWrite,
   output logic       regDst,
   output logic       memToReg,
   output logic       regWrite,
   output logic       illegalInstr,
   output logic       memFault,
   output logic [3:0] state
);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_FETCH    = 4'd1;
   localparam logic [3:0] S_DECODE   = 4'd2;
   localparam logic [3:0] S_REXEC    = 4'd3;
   localparam logic [3:0] S_RWB      = 4'd4;
   localparam logic [3:0] S_MEMADDR  = 4'd5;
   localparam logic [3:0] S_MEMREAD  = 4'd6;
   localparam logic [3:0] S_MEMWB    = 4'd7;
   localparam logic [3:0] S_MEMWRITE = 4'd8;
   localparam logic [3:0] S_IEXEC    = 4'd9;
   localparam logic [3:0] S_IWB      = 4'd10;
   localparam logic [3:0] S_BRANCH   = 4'd11;
   localparam logic [3:0] S_JUMP     = 4'd12;
   localparam logic [3:0] S_ILLEGAL  = 4'd13;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_ADDI = 6'h08;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_NOT = 4'b0010;
   localparam logic [3:0] ALU_LSL = 4'b0011;
   localparam logic [3:0] ALU_LSR = 4'b0100;
   localparam logic [3:0] ALU_AND = 4'b0101;
   localparam logic [3:0] ALU_OR  = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   logic [3:0] r_state;
   logic [3:0] w_next;
   logic [7:0] r_waitCnt;
   logic       w_waitState;
   logic       w_timeout;
   logic [3:0] w_rAlu;
   logic       w_functOk;
   logic       w_unused;

   // The zero flag qualifies pcWriteCond in the datapath; the FSM itself never branches on it.
   assign w_unused = zero;

   assign w_waitState = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
   assign w_timeout   = w_waitState && (r_waitCnt == 8'(MEM_TIMEOUT - 1));
   assign memFault    = w_timeout && !memReady;
   assign state       = r_state;

   always_comb begin
      w_rAlu    = ALU_ADD;
      w_functOk = 1'b1;
      case (funct)
         6'h20:   w_rAlu = ALU_ADD;
         6'h22:   w_rAlu = ALU_SUB;
         6'h24:   w_rAlu = ALU_AND;
         6'h25:   w_rAlu = ALU_OR;
         6'h2A:   w_rAlu = ALU_SLT;
         6'h00:   w_rAlu = ALU_LSL;
         6'h02:   w_rAlu = ALU_LSR;
         6'h27:   w_rAlu = ALU_NOT;
         default: w_functOk = 1'b0;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   w_next = S_FETCH;
         // memReady takes priority over a coincident timeout
         S_FETCH: begin
            if (memReady)       w_next = S_DECODE;
            else if (w_timeout) w_next = S_IDLE;
         end
         S_DECODE: begin
            case (opcode)
               OP_R:          w_next = S_REXEC;
               OP_LW, OP_SW:  w_next = S_MEMADDR;
               OP_BEQ:        w_next = S_BRANCH;
               OP_J:          w_next = S_JUMP;
               OP_ADDI:       w_next = S_IEXEC;
               default:       w_next = S_ILLEGAL;
            endcase
         end
         S_REXEC:   w_next = w_functOk ? S_RWB : S_ILLEGAL;
         S_MEMADDR: w_next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD: begin
            if (memReady)       w_next = S_MEMWB;
            else if (w_timeout) w_next = S_IDLE;
         end
         S_MEMWRITE: begin
            if (memReady)       w_next = S_FETCH;
            else if (w_timeout) w_next = S_IDLE;
         end
         S_IEXEC:   w_next = S_IWB;
         S_RWB, S_MEMWB, S_IWB, S_BRANCH, S_JUMP: w_next = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
         S_ILLEGAL: w_next = S_ILLEGAL;
`else
         S_ILLEGAL: w_next = S_FETCH;
`endif
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state   <= S_IDLE;
         r_waitCnt <= '0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state)
            r_waitCnt <= '0;
         else if (w_waitState)
            r_waitCnt <= r_waitCnt + 8'd1;
      end
   end

`ifdef ILLEGAL_TRAP_EN
   logic r_illegal;
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)
         r_illegal <= 1'b0;
      else if (w_next == S_ILLEGAL)
         r_illegal <= 1'b1;
   end
   assign illegalInstr = r_illegal;
`else
   assign illegalInstr = 1'b0;
`endif

   always_comb begin
      AluControl  = ALU_ADD;
      aluSrcA     = 1'b0;
      aluSrcB     = 2'b00;
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      pcSource    = 2'b00;
      iorD        = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      irWrite     = 1'b0;
      regDst      = 1'b0;
      memToReg    = 1'b0;
      regWrite    = 1'b0;
      case (r_state)
         S_FETCH: begin
            memRead = 1'b1;
            aluSrcB = 2'b01;
            irWrite = memReady;
            pcWrite = memReady;
         end
         S_DECODE: aluSrcB = 2'b11;
         S_REXEC: begin
            aluSrcA    = 1'b1;
            AluControl = w_rAlu;
         end
         S_RWB: begin
            regDst   = 1'b1;
            regWrite = 1'b1;
         end
         S_MEMADDR, S_IEXEC: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'b10;
         end
         S_MEMREAD: begin
            memRead = 1'b1;
            iorD    = 1'b1;
         end
         S_MEMWB: begin
            memToReg = 1'b1;
            regWrite = 1'b1;
         end
         S_MEMWRITE: begin
            memWrite = 1'b1;
            iorD     = 1'b1;
         end
         S_IWB: regWrite = 1'b1;
         S_BRANCH: begin
            aluSrcA     = 1'b1;
            AluControl  = ALU_SUB;
            pcWriteCond = 1'b1;
            pcSource    = 2'b01;
         end
         S_JUMP: begin
            pcWrite  = 1'b1;
            pcSource = 2'b10;
         end
         default: ;
      endcase
   end

endmodule
